// File: rtl/si_upscaler_dequant_seq_if.sv
// Handshake bundle for si_upscaler_dequant_seq.
// Both sides use valid/ready: a word moves on a rising clock edge where valid
// and ready are both high; valid, once raised, is held with stable data until
// that edge.
// slave  : the dequantizer's view (takes in, produces out).
// master : the surrounding producer/consumer view.
interface si_upscaler_dequant_seq_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 32
) ();
    logic [N_IN-1:0]  in;
    logic             in_valid;
    logic             in_ready;
    logic [N_OUT-1:0] out;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/si_upscaler_dequant_seq.sv
// si_upscaler_dequant_seq: inverse of the 32->8 requantizer.
// out = sat( sign(d) * (|d| * M_INV_0Q32) >> (32 - SHIFT) ), d = in - OFFSET.
// The magnitude product is built with a serial shift-add multiplier, one
// magnitude bit per clock (N_IN+1 cycles), followed by one normalise cycle.
// Optional build macro SI_DEQUANT_ROUND_EN: round half away from zero on the
// magnitude; when undefined the magnitude is truncated toward zero.
module si_upscaler_dequant_seq #(
    parameter int          N_IN       = 8,
    parameter int          N_OUT      = 32,
    parameter logic [31:0] M_INV_0Q32 = 32'd2386092942,
    parameter int          SHIFT      = 12,
    parameter int          OFFSET     = 22
) (
    input logic                        clk,
    input logic                        rst_n,
    si_upscaler_dequant_seq_if.slave   bus
);

    // Product of an (N_IN+1)-bit magnitude and a 32-bit mantissa.
    localparam int ACC_W = N_IN + 33;
    // Comparison width wide enough for both the shifted product and N_OUT.
    localparam int CMP_W = ((ACC_W > N_OUT) ? ACC_W : N_OUT) + 1;
    localparam int CNT_W = $clog2(N_IN + 2);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_IN);
    localparam logic [N_IN:0]    OFF      = OFFSET[N_IN:0];
    localparam logic [CMP_W-1:0] MAX_POS  = (CMP_W'(1) << (N_OUT - 1)) - CMP_W'(1);
    localparam logic [CMP_W-1:0] MAX_NEG  = MAX_POS + CMP_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [N_IN:0]      mag_sh;   // remaining magnitude bits, LSB is next
    logic [ACC_W-1:0]   mcand;    // mantissa aligned to the current bit
    logic [ACC_W-1:0]   acc;      // partial product
    logic [CNT_W-1:0]   cnt;
    logic               sgn;
    logic [N_OUT-1:0]   out_reg;

    logic               accept;
    logic               release_out;
    logic               in_ready_c;

    // Zero-point removal in N_IN+1 bits, which cannot overflow.
    logic [N_IN:0]      d;
    logic [N_IN:0]      d_mag;

    // Normalise path.
    logic [ACC_W-1:0]   r_mag;
    logic [CMP_W-1:0]   r_ext;
    logic [CMP_W-1:0]   r_signed;
    logic [N_OUT-1:0]   result;

    // FSM next-state and handshake decode.
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        accept      = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = MUL;
                end
            end
            MUL: begin
                if (cnt == LAST_BIT) begin
                    next_state = NORM;
                end
            end
            NORM: begin
                next_state = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sign/magnitude of the zero-point-corrected input.
    always_comb begin
        d     = {bus.in[N_IN-1], bus.in} - OFF;
        d_mag = d[N_IN] ? (~d + 1'b1) : d;
    end

    // Shift, optional round, saturate and apply sign to the finished product.
    always_comb begin
        r_mag = acc >> (32 - SHIFT);
`ifdef SI_DEQUANT_ROUND_EN
        r_mag = r_mag + ACC_W'(acc[31 - SHIFT]);
`endif
        r_ext    = CMP_W'(r_mag);
        r_signed = sgn ? (~r_ext + 1'b1) : r_ext;
        if (!sgn && (r_ext > MAX_POS)) begin
            result = {1'b0, {(N_OUT-1){1'b1}}};
        end else if (sgn && (r_ext > MAX_NEG)) begin
            result = {1'b1, {(N_OUT-1){1'b0}}};
        end else begin
            result = r_signed[N_OUT-1:0];
        end
    end

    // Serial multiplier datapath and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_sh  <= '0;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_sh <= d_mag;
                        sgn    <= d[N_IN];
                        mcand  <= ACC_W'(M_INV_0Q32);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (mag_sh[0]) begin
                        acc <= acc + mcand;
                    end
                    mag_sh <= mag_sh >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt + 1'b1;
                end
                NORM: begin
                    out_reg <= result;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_reg;

    // release_out marks the output handshake edge; it is kept for probing.
    logic unused_release;
    assign unused_release = release_out;

endmodule
